// File: rtl/imm_decode_ctrl_if.sv
// Handshake and decoded-slot bundle between fetch, the immediate-decode
// control stage and execute.
interface imm_decode_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_ready;
  logic             flush;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             out_valid;
  logic [5:0]       out_extop;
  logic [4:0]       out_iimm_shamt;
  logic [11:0]      out_iimm;
  logic [11:0]      out_simm;
  logic [11:0]      out_bimm;
  logic [19:0]      out_uimm;
  logic [19:0]      out_jimm;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_instr, out_ready, flush, ex_memread, ex_rd,
    input  in_ready, out_valid, out_extop, out_iimm_shamt, out_iimm,
           out_simm, out_bimm, out_uimm, out_jimm, out_rs1, out_rs2,
           out_rd, out_illegal, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, out_ready, flush, ex_memread, ex_rd,
    output in_ready, out_valid, out_extop, out_iimm_shamt, out_iimm,
           out_simm, out_bimm, out_uimm, out_jimm, out_rs1, out_rs2,
           out_rd, out_illegal, stall_cnt
  );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Single-register decode stage: classifies RV32I words into EXT immediate
// selects, slices fields, and inserts bubbles on load-use hazards.
module imm_decode_ctrl #(
  parameter int         CNT_W        = 16,
  parameter logic [5:0] BUBBLE_EXTOP = 6'b000000
) (
  input logic              clk,
  input logic              rst,
  imm_decode_ctrl_if.slave bus
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_ITYPE = 6'b010000;
  localparam logic [5:0] EXT_STYPE = 6'b001000;
  localparam logic [5:0] EXT_BTYPE = 6'b000100;
  localparam logic [5:0] EXT_UTYPE = 6'b000010;
  localparam logic [5:0] EXT_JTYPE = 6'b000001;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       instrRs1;
  logic [4:0]       instrRs2;
  logic [4:0]       instrRd;
  logic [5:0]       decExtop;
  logic             decIllegal;
  logic             usesRs1;
  logic             usesRs2;
  logic             hazard;
  logic             slotFree;

  logic             outValid_q,   outValid_d;
  logic [5:0]       outExtop_q,   outExtop_d;
  logic             outIllegal_q, outIllegal_d;
  logic [4:0]       shamt_q,      shamt_d;
  logic [11:0]      iImm_q,       iImm_d;
  logic [11:0]      sImm_q,       sImm_d;
  logic [11:0]      bImm_q,       bImm_d;
  logic [19:0]      uImm_q,       uImm_d;
  logic [19:0]      jImm_q,       jImm_d;
  logic [4:0]       rs1_q,        rs1_d;
  logic [4:0]       rs2_q,        rs2_d;
  logic [4:0]       rd_q,         rd_d;
  logic [CNT_W-1:0] stallCnt_q,   stallCnt_d;
  logic [CNT_W-1:0] stallCntSat;

  assign opcode   = bus.in_instr[6:0];
  assign funct3   = bus.in_instr[14:12];
  assign instrRs1 = bus.in_instr[19:15];
  assign instrRs2 = bus.in_instr[24:20];
  assign instrRd  = bus.in_instr[11:7];

  // Unrecognised opcodes count as reading rs1 so a stall is never missed.
  always_comb begin
    decExtop   = BUBBLE_EXTOP;
    decIllegal = 1'b0;
    usesRs1    = 1'b1;
    usesRs2    = 1'b0;
    case (opcode)
      OP_IMM:    decExtop = (funct3 == 3'b001 || funct3 == 3'b101) ? EXT_SHAMT : EXT_ITYPE;
      OP_LOAD,
      OP_JALR:   decExtop = EXT_ITYPE;
      OP_STORE: begin
        decExtop = EXT_STYPE;
        usesRs2  = 1'b1;
      end
      OP_BRANCH: begin
        decExtop = EXT_BTYPE;
        usesRs2  = 1'b1;
      end
      OP_LUI,
      OP_AUIPC: begin
        decExtop = EXT_UTYPE;
        usesRs1  = 1'b0;
      end
      OP_JAL: begin
        decExtop = EXT_JTYPE;
        usesRs1  = 1'b0;
      end
      OP_REG:    usesRs2 = 1'b1;
      default:   decIllegal = 1'b1;
    endcase
  end

  always_comb begin
    hazard = bus.ex_memread && (bus.ex_rd != 5'd0) && bus.in_valid &&
             ((usesRs1 && bus.ex_rd == instrRs1) || (usesRs2 && bus.ex_rd == instrRs2));
    slotFree    = !outValid_q || bus.out_ready;
    stallCntSat = (&stallCnt_q) ? stallCnt_q : stallCnt_q + CNT_W'(1);
  end

  assign bus.in_ready = bus.flush || (slotFree && !hazard);

  // Priority: flush, then load-use stall, then accept, then drain.
  always_comb begin
    outValid_d   = outValid_q;
    outExtop_d   = outExtop_q;
    outIllegal_d = outIllegal_q;
    shamt_d      = shamt_q;
    iImm_d       = iImm_q;
    sImm_d       = sImm_q;
    bImm_d       = bImm_q;
    uImm_d       = uImm_q;
    jImm_d       = jImm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    stallCnt_d   = stallCnt_q;
    if (bus.flush) begin
      outValid_d   = 1'b0;
      outIllegal_d = 1'b0;
    end else if (hazard) begin
      stallCnt_d = stallCntSat;
      if (slotFree) begin
        outValid_d   = 1'b0;
        outExtop_d   = BUBBLE_EXTOP;
        outIllegal_d = 1'b0;
      end
    end else if (bus.in_valid && slotFree) begin
      outValid_d   = 1'b1;
      outExtop_d   = decExtop;
      outIllegal_d = decIllegal;
      shamt_d      = bus.in_instr[24:20];
      iImm_d       = bus.in_instr[31:20];
      sImm_d       = {bus.in_instr[31:25], bus.in_instr[11:7]};
      bImm_d       = {bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25], bus.in_instr[11:8]};
      uImm_d       = bus.in_instr[31:12];
      jImm_d       = {bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20], bus.in_instr[30:21]};
      rs1_d        = instrRs1;
      rs2_d        = instrRs2;
      rd_d         = instrRd;
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q   <= 1'b0;
      outExtop_q   <= BUBBLE_EXTOP;
      outIllegal_q <= 1'b0;
      shamt_q      <= '0;
      iImm_q       <= '0;
      sImm_q       <= '0;
      bImm_q       <= '0;
      uImm_q       <= '0;
      jImm_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      stallCnt_q   <= '0;
    end else begin
      outValid_q   <= outValid_d;
      outExtop_q   <= outExtop_d;
      outIllegal_q <= outIllegal_d;
      shamt_q      <= shamt_d;
      iImm_q       <= iImm_d;
      sImm_q       <= sImm_d;
      bImm_q       <= bImm_d;
      uImm_q       <= uImm_d;
      jImm_q       <= jImm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      stallCnt_q   <= stallCnt_d;
    end
  end

  assign bus.out_valid      = outValid_q;
  assign bus.out_extop      = outExtop_q;
  assign bus.out_illegal    = outIllegal_q;
  assign bus.out_iimm_shamt = shamt_q;
  assign bus.out_iimm       = iImm_q;
  assign bus.out_simm       = sImm_q;
  assign bus.out_bimm       = bImm_q;
  assign bus.out_uimm       = uImm_q;
  assign bus.out_jimm       = jImm_q;
  assign bus.out_rs1        = rs1_q;
  assign bus.out_rs2        = rs2_q;
  assign bus.out_rd         = rd_q;
  assign bus.stall_cnt      = stallCnt_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Bench for imm_decode_ctrl: directed scenarios plus a randomized run against
// an instruction-level reference model.
module tb_imm_decode_ctrl;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  imm_decode_ctrl_if #(.CNT_W(TB_CNT_W)) bif ();

  imm_decode_ctrl #(
    .CNT_W(TB_CNT_W),
    .BUBBLE_EXTOP(6'b000000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction classes: 0 illegal, 1 R, 2 I, 3 shift-imm, 4 S, 5 B, 6 U, 7 J.
  function automatic int classOf(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return 1;
      7'b0010011: return (w[13:12] == 2'b01) ? 3 : 2;
      7'b0000011, 7'b1100111: return 2;
      7'b0100011: return 4;
      7'b1100011: return 5;
      7'b0110111, 7'b0010111: return 6;
      7'b1101111: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic logic [5:0] extopOf(input int cls);
    logic [5:0] table_[8] = '{6'b000000, 6'b000000, 6'b010000, 6'b100000,
                              6'b001000, 6'b000100, 6'b000010, 6'b000001};
    return table_[cls];
  endfunction

  function automatic logic [95:0] fieldsOf(input logic [31:0] w);
    return {w[24:20], w[31:20], w[31:25], w[11:7],
            w[31], w[7], w[30:25], w[11:8], w[31:12],
            w[31], w[19:12], w[20], w[30:21],
            w[19:15], w[24:20], w[11:7]};
  endfunction

  function automatic logic [95:0] dutFields();
    return {bif.out_iimm_shamt, bif.out_iimm, bif.out_simm, bif.out_bimm,
            bif.out_uimm, bif.out_jimm, bif.out_rs1, bif.out_rs2, bif.out_rd};
  endfunction

  task automatic applyStimulus(input logic iv, input logic [31:0] instr,
                               input logic ordy, input logic fl,
                               input logic mr, input logic [4:0] erd);
    bif.in_valid   = iv;
    bif.in_instr   = instr;
    bif.out_ready  = ordy;
    bif.flush      = fl;
    bif.ex_memread = mr;
    bif.ex_rd      = erd;
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_extop !== 6'b000000 || bif.out_illegal !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got valid=%b extop=%b illegal=%b, want 0/000000/0",
               bif.out_valid, bif.out_extop, bif.out_illegal);
    end
    checks++;
    if (dutFields() !== 96'h0 || bif.stall_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL reset_fields: got fields=%h cnt=%0d, want all zero",
               dutFields(), bif.stall_cnt);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;
  endtask

  task automatic test_immediates();
    applyReset();
    applyStimulus(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_extop !== 6'b010000 ||
        bif.out_iimm !== 12'h005 || bif.out_rd !== 5'd1) begin
      failures++;
      $display("[TB] FAIL addi: got valid=%b extop=%b iimm=%h rd=%0d, want 1/010000/005/1",
               bif.out_valid, bif.out_extop, bif.out_iimm, bif.out_rd);
    end
    applyStimulus(1'b1, 32'h00309113, 1'b1, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_extop !== 6'b100000 ||
        bif.out_iimm_shamt !== 5'd3 || bif.out_rs1 !== 5'd1) begin
      failures++;
      $display("[TB] FAIL slli: got valid=%b extop=%b shamt=%0d rs1=%0d, want 1/100000/3/1",
               bif.out_valid, bif.out_extop, bif.out_iimm_shamt, bif.out_rs1);
    end
    applyStimulus(1'b1, 32'h008000EF, 1'b1, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_extop !== 6'b000001 ||
        bif.out_jimm !== 20'h00004 || bif.out_rd !== 5'd1) begin
      failures++;
      $display("[TB] FAIL jal: got valid=%b extop=%b jimm=%h rd=%0d, want 1/000001/00004/1",
               bif.out_valid, bif.out_extop, bif.out_jimm, bif.out_rd);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_jimm !== 20'h00004) begin
      failures++;
      $display("[TB] FAIL drain_hold: got valid=%b jimm=%h, want 0/00004",
               bif.out_valid, bif.out_jimm);
    end
  endtask

  task automatic test_load_use();
    applyReset();
    applyStimulus(1'b1, 32'h00728333, 1'b1, 1'b0, 1'b1, 5'd5);
    #1;
    checks++;
    if (bif.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL loaduse_ready: got in_ready=%b, want 0", bif.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_extop !== 6'b000000 ||
        bif.out_illegal !== 1'b0 || bif.stall_cnt !== 4'd1) begin
      failures++;
      $display("[TB] FAIL loaduse_bubble: got valid=%b extop=%b illegal=%b cnt=%0d, want 0/000000/0/1",
               bif.out_valid, bif.out_extop, bif.out_illegal, bif.stall_cnt);
    end
    applyStimulus(1'b1, 32'h00728333, 1'b1, 1'b0, 1'b0, 5'd5);
    #1;
    checks++;
    if (bif.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL loaduse_release: got in_ready=%b, want 1", bif.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_rd !== 5'd6 || bif.out_rs1 !== 5'd5 ||
        bif.out_rs2 !== 5'd7 || bif.out_extop !== 6'b000000 || bif.stall_cnt !== 4'd1) begin
      failures++;
      $display("[TB] FAIL loaduse_accept: got valid=%b rd=%0d rs1=%0d rs2=%0d extop=%b cnt=%0d, want 1/6/5/7/000000/1",
               bif.out_valid, bif.out_rd, bif.out_rs1, bif.out_rs2, bif.out_extop, bif.stall_cnt);
    end
  endtask

  task automatic test_flush();
    applyReset();
    applyStimulus(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h123450B7, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    checks++;
    if (bif.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_backpressure: got in_ready=%b, want 0", bif.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_rd !== 5'd1 || bif.out_iimm !== 12'h005) begin
      failures++;
      $display("[TB] FAIL full_hold: got valid=%b rd=%0d iimm=%h, want 1/1/005",
               bif.out_valid, bif.out_rd, bif.out_iimm);
    end
    applyStimulus(1'b1, 32'h00728333, 1'b0, 1'b1, 1'b1, 5'd5);
    #1;
    checks++;
    if (bif.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_ready: got in_ready=%b, want 1", bif.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_illegal !== 1'b0 || bif.stall_cnt !== 4'd0 ||
        bif.out_rd !== 5'd1) begin
      failures++;
      $display("[TB] FAIL flush_kill: got valid=%b illegal=%b cnt=%0d rd=%0d, want 0/0/0/1",
               bif.out_valid, bif.out_illegal, bif.stall_cnt, bif.out_rd);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bif.out_valid !== 1'b0 || bif.out_rd !== 5'd1) begin
        failures++;
        $display("[TB] FAIL flush_no_emit: cycle %0d got valid=%b rd=%0d, want 0/1",
                 i, bif.out_valid, bif.out_rd);
      end
    end
  endtask

  task automatic test_illegal_and_reset_mid_stall();
    applyReset();
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_illegal !== 1'b1 || bif.out_extop !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL illegal: got valid=%b illegal=%b extop=%b, want 1/1/000000",
               bif.out_valid, bif.out_illegal, bif.out_extop);
    end
    applyStimulus(1'b1, 32'h00728333, 1'b0, 1'b0, 1'b1, 5'd7);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bif.stall_cnt !== 4'd2 || bif.out_valid !== 1'b1 || bif.out_illegal !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_hold: got cnt=%0d valid=%b illegal=%b, want 2/1/1",
               bif.stall_cnt, bif.out_valid, bif.out_illegal);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_illegal !== 1'b0 || bif.out_extop !== 6'b000000 ||
        dutFields() !== 96'h0 || bif.stall_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: got valid=%b illegal=%b extop=%b fields=%h cnt=%0d, want all zero",
               bif.out_valid, bif.out_illegal, bif.out_extop, dutFields(), bif.stall_cnt);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_saturation();
    applyReset();
    applyStimulus(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h00728333, 1'b0, 1'b0, 1'b1, 5'd5);
    repeat (CNT_MAX + 5) @(posedge clk);
    #1;
    checks++;
    if (bif.stall_cnt !== 4'd15 || bif.out_valid !== 1'b1 || bif.out_rd !== 5'd1) begin
      failures++;
      $display("[TB] FAIL saturate: got cnt=%0d valid=%b rd=%0d, want 15/1/1",
               bif.stall_cnt, bif.out_valid, bif.out_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    applyReset();
    for (int i = 0; i < 8; i++) begin
      w = $urandom();
      w[6:0]   = 7'b0000011;
      w[14:12] = 3'b010;
      applyStimulus(1'b1, w, 1'b1, 1'b0, 1'b0, 5'd0);
      #1;
      checks++;
      if (bif.in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_ready: beat %0d got in_ready=%b, want 1", i, bif.in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (bif.out_valid !== 1'b1 || bif.out_extop !== 6'b010000 ||
          bif.out_iimm !== w[31:20] || bif.out_rd !== w[11:7]) begin
        failures++;
        $display("[TB] FAIL b2b_beat: beat %0d got valid=%b extop=%b iimm=%h rd=%0d, want 1/010000/%h/%0d",
                 i, bif.out_valid, bif.out_extop, bif.out_iimm, bif.out_rd, w[31:20], w[11:7]);
      end
    end
  endtask

  task automatic test_random_model();
    logic [6:0]  ops[11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001011,
                             7'b1111111};
    logic [31:0] w;
    logic [31:0] slotWord;
    logic        iv, ordy, fl, mr;
    logic [4:0]  erd;
    bit          mValid, mIllegal, readsRs1, readsRs2, hz, free, expReady;
    logic [5:0]  mExtop;
    int          mCnt, cls;
    applyReset();
    slotWord = 32'h0;
    mValid   = 1'b0;
    mIllegal = 1'b0;
    mExtop   = 6'b000000;
    mCnt     = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 10)];
      cls  = classOf(w);
      iv   = ($urandom_range(0, 99) < 75);
      ordy = ($urandom_range(0, 99) < 60);
      fl   = ($urandom_range(0, 99) < 8);
      mr   = (cls != 0) && ($urandom_range(0, 99) < 45);
      case ($urandom_range(0, 3))
        0: erd = w[19:15];
        1: erd = w[24:20];
        2: erd = 5'($urandom());
        default: erd = 5'd0;
      endcase
      applyStimulus(iv, w, ordy, fl, mr, erd);

      readsRs1 = (cls >= 1 && cls <= 5);
      readsRs2 = (cls == 1 || cls == 4 || cls == 5);
      hz   = mr && erd != 5'd0 && iv &&
             ((readsRs1 && erd == w[19:15]) || (readsRs2 && erd == w[24:20]));
      free = !mValid || ordy;
      expReady = fl || (free && !hz);
      #1;
      checks++;
      if (bif.in_ready !== expReady) begin
        failures++;
        $display("[TB] FAIL rand_ready: cycle %0d instr=%h got in_ready=%b, want %b",
                 cyc, w, bif.in_ready, expReady);
      end

      if (fl) begin
        mValid   = 1'b0;
        mIllegal = 1'b0;
      end else if (hz) begin
        if (mCnt < CNT_MAX) mCnt++;
        if (free) begin
          mValid   = 1'b0;
          mExtop   = 6'b000000;
          mIllegal = 1'b0;
        end
      end else if (iv && free) begin
        mValid   = 1'b1;
        slotWord = w;
        mExtop   = extopOf(cls);
        mIllegal = (cls == 0);
      end else if (ordy) begin
        mValid = 1'b0;
      end

      @(posedge clk); #1;
      checks++;
      if (bif.out_valid !== mValid || bif.stall_cnt !== TB_CNT_W'(mCnt) ||
          dutFields() !== fieldsOf(slotWord)) begin
        failures++;
        $display("[TB] FAIL rand_slot: cycle %0d got valid=%b cnt=%0d fields=%h, want %b/%0d/%h",
                 cyc, bif.out_valid, bif.stall_cnt, dutFields(), mValid, mCnt, fieldsOf(slotWord));
      end
      if (mValid) begin
        checks++;
        if (bif.out_extop !== mExtop || bif.out_illegal !== mIllegal) begin
          failures++;
          $display("[TB] FAIL rand_decode: cycle %0d word=%h got extop=%b illegal=%b, want %b/%b",
                   cyc, slotWord, bif.out_extop, bif.out_illegal, mExtop, mIllegal);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_immediates();
    test_load_use();
    test_flush();
    test_illegal_and_reset_mid_stall();
    test_saturation();
    test_back_to_back();
    test_random_model();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
